// File: rtl/mem_arbiter_pkg.sv
// Shared memory-link definitions: arbiter FSM states, port indices, request record.
// No logic; latency and backpressure are properties of the modules that import it.
// Used by mem_arbiter and mem_req_slot.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] size;
    logic [1:0] memwrite;
  } mem_req_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep request holding register with pending flag for one arbiter port.
// Latency: captured on the edge that samples start; pending visible the next cycle.
// Backpressure: start is dropped whenever the owning port reports busy.
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  logic     busy,
  input  mem_req_t req,
  input  logic     grant,
  output logic     pending,
  output mem_req_t held
);

  // grant only fires while pending, and pending implies busy, so the two never collide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      held    <= '0;
    end else if (start && !busy) begin
      pending <= 1'b1;
      held    <= req;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto a single UART memory link controller.
// Latency: start to enable 2 edges; ack the cycle after mc_mem_done; 2 idle cycles between jobs.
// Backpressure: per-port busy; a start seen while busy (including the ack cycle) is dropped.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_start,
  input  logic [7:0] f_addr,
  input  logic [2:0] f_size,
  output logic       f_busy,
  output logic       f_ack,
  output logic [7:0] f_rdata,
  input  logic       d_start,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  input  logic [2:0] d_size,
  input  logic [1:0] d_memwrite,
  output logic       d_busy,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       mc_write_enable,
  output logic       mc_read_enable,
  output logic [7:0] mc_address,
  output logic [7:0] mc_writeData,
  output logic [2:0] mc_SizeLoad,
  output logic [1:0] mc_MemWrite,
  input  logic       mc_mem_done,
  input  logic [7:0] mc_readData
);

  arb_state_t state, state_nxt;
  logic       gnt_port, gnt_port_nxt, last_gnt, pick;
  logic       f_pend, d_pend, f_grant, d_grant;
  mem_req_t   f_req, d_req, f_held, d_held, mc_req, mc_req_nxt;

  assign f_req = '{we: 1'b0, addr: f_addr, wdata: 8'h00, size: f_size, memwrite: 2'b00};
  assign d_req = '{we: d_we, addr: d_addr, wdata: d_wdata, size: d_size, memwrite: d_memwrite};

  assign f_busy = f_pend || (state != ST_IDLE && gnt_port == PORT_FETCH);
  assign d_busy = d_pend || (state != ST_IDLE && gnt_port == PORT_DATA);

  mem_req_slot u_fetch_slot (
    .clk(clk), .reset(reset), .start(f_start), .busy(f_busy),
    .req(f_req), .grant(f_grant), .pending(f_pend), .held(f_held)
  );

  mem_req_slot u_data_slot (
    .clk(clk), .reset(reset), .start(d_start), .busy(d_busy),
    .req(d_req), .grant(d_grant), .pending(d_pend), .held(d_held)
  );

  always_comb begin
    state_nxt    = state;
    gnt_port_nxt = gnt_port;
    mc_req_nxt   = mc_req;
    pick         = PORT_FETCH;
    f_grant      = 1'b0;
    d_grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (f_pend || d_pend) begin
          if (f_pend && d_pend) pick = (FIXED_PRIO != 0) ? PORT_DATA : ~last_gnt;
          else                  pick = d_pend ? PORT_DATA : PORT_FETCH;
          gnt_port_nxt = pick;
          mc_req_nxt   = (pick == PORT_DATA) ? d_held : f_held;
          f_grant      = (pick == PORT_FETCH);
          d_grant      = (pick == PORT_DATA);
          state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: if (mc_mem_done) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt_port <= PORT_FETCH;
      last_gnt <= PORT_DATA;
      mc_req   <= '0;
      f_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      gnt_port <= gnt_port_nxt;
      mc_req   <= mc_req_nxt;
      if (state == ST_RESP) last_gnt <= gnt_port;
      if (state == ST_ISSUE && mc_mem_done && !mc_req.we) begin
        if (gnt_port == PORT_DATA) d_rdata <= mc_readData;
        else                       f_rdata <= mc_readData;
      end
    end
  end

  // enables drop in RESP so the link controller sees a clean idle cycle after done
  assign mc_read_enable  = (state == ST_ISSUE) && !mc_req.we;
  assign mc_write_enable = (state == ST_ISSUE) &&  mc_req.we;
  assign f_ack = (state == ST_RESP) && (gnt_port == PORT_FETCH);
  assign d_ack = (state == ST_RESP) && (gnt_port == PORT_DATA);

  assign mc_address   = mc_req.addr;
  assign mc_writeData = mc_req.wdata;
  assign mc_SizeLoad  = mc_req.size;
  assign mc_MemWrite  = mc_req.memwrite;

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (round-robin and fixed-priority) share one stimulus stream; each has its own link model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       f_start = 1'b0, d_start = 1'b0, d_we = 1'b0;
  logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] f_size = '0, d_size = '0;
  logic [1:0] d_memwrite = '0;

  logic       f_busy [2], f_ack [2], d_busy [2], d_ack [2];
  logic       mc_we [2], mc_re [2], mc_mem_done [2];
  logic [7:0] f_rdata [2], d_rdata [2], mc_address [2], mc_writeData [2], mc_readData [2];
  logic [2:0] mc_SizeLoad [2];
  logic [1:0] mc_MemWrite [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.FIXED_PRIO(gi)) u_dut (
      .clk(clk), .reset(reset),
      .f_start(f_start), .f_addr(f_addr), .f_size(f_size),
      .f_busy(f_busy[gi]), .f_ack(f_ack[gi]), .f_rdata(f_rdata[gi]),
      .d_start(d_start), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_size(d_size), .d_memwrite(d_memwrite),
      .d_busy(d_busy[gi]), .d_ack(d_ack[gi]), .d_rdata(d_rdata[gi]),
      .mc_write_enable(mc_we[gi]), .mc_read_enable(mc_re[gi]),
      .mc_address(mc_address[gi]), .mc_writeData(mc_writeData[gi]),
      .mc_SizeLoad(mc_SizeLoad[gi]), .mc_MemWrite(mc_MemWrite[gi]),
      .mc_mem_done(mc_mem_done[gi]), .mc_readData(mc_readData[gi])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- link controller model ----------------
  bit         link_fixed = 1'b0;
  logic [7:0] link_val = 8'h00;
  int         link_lat_max = 0;
  bit         spur_en = 1'b0;
  int         lat [2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mc_mem_done[i] = 1'b0;
        mc_readData[i] = 8'h00;
        lat[i] = 0;
      end else begin
        mc_mem_done[i] = 1'b0;
        if (mc_re[i] || mc_we[i]) begin
          if (lat[i] == 0) begin
            mc_mem_done[i] = 1'b1;
            mc_readData[i] = link_fixed ? link_val : 8'($urandom);
            lat[i] = int'($urandom_range(0, link_lat_max));
          end else begin
            lat[i]--;
          end
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
          mc_mem_done[i] = 1'b1;
          mc_readData[i] = 8'($urandom);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit         m_pend [2][2];
  mem_req_t   m_req [2][2];
  int         m_act [2];     // port in service, -1 when none
  bit         m_resp [2];    // completion already seen, ack cycle
  int         m_last [2];
  logic [7:0] m_rd [2][2];
  mem_req_t   m_mc [2];

  always @(posedge clk or posedge reset) begin
    bit       b [2];
    bit       st [2];
    mem_req_t rq [2];
    int       g;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int p = 0; p < 2; p++) begin
          m_pend[i][p] = 1'b0;
          m_req[i][p]  = '0;
          m_rd[i][p]   = 8'h00;
        end
        m_act[i]  = -1;
        m_resp[i] = 1'b0;
        m_last[i] = 1;
        m_mc[i]   = '0;
      end else begin
        rq[0] = '{we: 1'b0, addr: f_addr, wdata: 8'h00, size: f_size, memwrite: 2'b00};
        rq[1] = '{we: d_we, addr: d_addr, wdata: d_wdata, size: d_size, memwrite: d_memwrite};
        st[0] = f_start;
        st[1] = d_start;
        for (int p = 0; p < 2; p++) b[p] = m_pend[i][p] || (m_act[i] == p);
        if (m_resp[i]) begin
          m_last[i] = m_act[i];
          m_act[i]  = -1;
          m_resp[i] = 1'b0;
        end else if (m_act[i] >= 0) begin
          if (mc_mem_done[i]) begin
            if (!m_mc[i].we) m_rd[i][m_act[i]] = mc_readData[i];
            m_resp[i] = 1'b1;
          end
        end else if (m_pend[i][0] || m_pend[i][1]) begin
          if (m_pend[i][0] && m_pend[i][1]) g = (i == 1) ? 1 : 1 - m_last[i];
          else                               g = m_pend[i][1] ? 1 : 0;
          m_act[i] = g;
          m_pend[i][g] = 1'b0;
          m_mc[i] = m_req[i][g];
        end
        for (int p = 0; p < 2; p++) begin
          if (st[p] && !b[p]) begin
            m_req[i][p]  = rq[p];
            m_pend[i][p] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- compare + ack log ----------------
  bit          chk_en = 1'b0;
  int          n_fack [2] = '{0, 0};
  int          n_dack [2] = '{0, 0};
  int          same_run [2] = '{0, 0};
  bit          prev_port [2] = '{0, 0};
  bit          have_prev [2] = '{0, 0};
  logic [63:0] hist [2] = '{64'd0, 64'd0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit ena;
        ena = (m_act[i] >= 0) && !m_resp[i];
        check("f_busy", i, f_busy[i], m_pend[i][0] || m_act[i] == 0);
        check("d_busy", i, d_busy[i], m_pend[i][1] || m_act[i] == 1);
        check("f_ack", i, f_ack[i], m_resp[i] && m_act[i] == 0);
        check("d_ack", i, d_ack[i], m_resp[i] && m_act[i] == 1);
        check("mc_read_enable", i, mc_re[i], ena && !m_mc[i].we);
        check("mc_write_enable", i, mc_we[i], ena && m_mc[i].we);
        check("mc_fields", i, {mc_address[i], mc_writeData[i], mc_SizeLoad[i], mc_MemWrite[i]},
              {m_mc[i].addr, m_mc[i].wdata, m_mc[i].size, m_mc[i].memwrite});
        check("f_rdata", i, f_rdata[i], m_rd[i][0]);
        check("d_rdata", i, d_rdata[i], m_rd[i][1]);
        if (f_ack[i] || d_ack[i]) begin
          if (f_ack[i]) n_fack[i]++;
          else          n_dack[i]++;
          if (have_prev[i] && prev_port[i] == d_ack[i]) same_run[i]++;
          prev_port[i] = d_ack[i];
          have_prev[i] = 1'b1;
          hist[i] = {hist[i][62:0], d_ack[i]};
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_f(input logic [7:0] a, input logic [2:0] s);
    f_start = 1'b1; f_addr = a; f_size = s;
  endtask

  task automatic req_d(input logic we, input logic [7:0] a, input logic [7:0] w,
                       input logic [2:0] s, input logic [1:0] mw);
    d_start = 1'b1; d_we = we; d_addr = a; d_wdata = w; d_size = s; d_memwrite = mw;
  endtask

  task automatic no_req();
    f_start = 1'b0;
    d_start = 1'b0;
  endtask

  task automatic wait_acks(input int t0, input int t1);
    for (int k = 0; k < 300; k++) begin
      if (n_fack[0] + n_dack[0] >= t0 && n_fack[1] + n_dack[1] >= t1) break;
      step();
    end
    check("ack_wait", 0, n_fack[0] + n_dack[0] >= t0, 1);
    check("ack_wait", 1, n_fack[1] + n_dack[1] >= t1, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (!f_busy[0] && !d_busy[0] && !f_busy[1] && !d_busy[1]) break;
      step();
    end
    check("idle_wait", 0, {f_busy[0], d_busy[0]}, 0);
    check("idle_wait", 1, {f_busy[1], d_busy[1]}, 0);
  endtask

  int snap_f [2], snap_d [2], snap_run [2];

  initial begin
    step();
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", i, {f_busy[i], d_busy[i]}, 0);
      check("rst_enables", i, {mc_re[i], mc_we[i]}, 0);
      check("rst_rdata", i, {f_rdata[i], d_rdata[i]}, 0);
      check("rst_mc_addr", i, mc_address[i], 0);
    end
    reset = 1'b0;
    step();

    // fetch read returning 0xA5
    link_fixed = 1'b1; link_val = 8'hA5;
    req_f(8'h10, 3'b010); step(); no_req();
    wait_acks(1, 1);
    for (int i = 0; i < 2; i++) begin
      check("fetch_rdata", i, f_rdata[i], 8'hA5);
      check("fetch_addr", i, mc_address[i], 8'h10);
      check("fetch_size", i, mc_SizeLoad[i], 3'b010);
      check("fetch_ack_count", i, n_fack[i], 1);
      check("fetch_busy_after_ack", i, f_busy[i], 0);
    end

    // data write
    link_fixed = 1'b0;
    req_d(1'b1, 8'h20, 8'h3C, 3'b000, 2'b01); step(); no_req();
    wait_acks(2, 2);
    for (int i = 0; i < 2; i++) begin
      check("write_addr", i, mc_address[i], 8'h20);
      check("write_data", i, mc_writeData[i], 8'h3C);
      check("write_memwrite", i, mc_MemWrite[i], 2'b01);
      check("write_d_rdata_held", i, d_rdata[i], 8'h00);
      check("write_ack_count", i, n_dack[i], 1);
    end

    // simultaneous starts, four rounds
    for (int r = 0; r < 4; r++) begin
      snap_f[0] = n_fack[0] + n_dack[0];
      snap_f[1] = n_fack[1] + n_dack[1];
      req_f(8'h30 + 8'(r), 3'b001);
      req_d(1'b0, 8'h40 + 8'(r), 8'h00, 3'b001, 2'b00);
      step(); no_req();
      wait_acks(snap_f[0] + 2, snap_f[1] + 2);
    end
    check("tie_order_rr", 0, hist[0][7:0], 8'b0101_0101);
    check("tie_order_fixed", 1, hist[1][7:0], 8'b1010_1010);

    // both ports restarting continuously
    link_lat_max = 2;
    for (int i = 0; i < 2; i++) begin
      snap_f[i] = n_fack[i]; snap_d[i] = n_dack[i]; snap_run[i] = same_run[i];
    end
    for (int c = 0; c < 150; c++) begin
      req_f(8'($urandom), 3'($urandom));
      req_d(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 2'($urandom));
      step();
    end
    no_req();
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      check("cont_fetch_served", i, n_fack[i] - snap_f[i] > 5, 1);
      check("cont_data_served", i, n_dack[i] - snap_d[i] > 5, 1);
      check("cont_alternation", i, same_run[i] - snap_run[i], 0);
    end

    // restart while busy is dropped
    snap_d[0] = n_dack[0]; snap_d[1] = n_dack[1];
    req_d(1'b1, 8'h55, 8'h11, 3'b000, 2'b01); step();
    req_d(1'b0, 8'h66, 8'h00, 3'b000, 2'b00); step(); step();
    no_req();
    wait_idle();
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      check("busy_restart_acks", i, n_dack[i] - snap_d[i], 1);
      check("busy_restart_addr", i, mc_address[i], 8'h55);
    end

    // randomized traffic with spurious done pulses
    spur_en = 1'b1; link_lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      f_start = ($urandom_range(0, 2) == 0);
      f_addr = 8'($urandom); f_size = 3'($urandom);
      d_start = ($urandom_range(0, 2) == 0);
      d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = 8'($urandom);
      d_size = 3'($urandom); d_memwrite = 2'($urandom);
      step();
    end
    no_req();
    wait_idle();
    spur_en = 1'b0;

    // reset during ISSUE
    req_f(8'h44, 3'b001); step(); no_req();
    for (int k = 0; k < 20 && !mc_re[0]; k++) step();
    check("issue_reached", 0, mc_re[0], 1);
    for (int i = 0; i < 2; i++) begin
      snap_f[i] = n_fack[i]; snap_d[i] = n_dack[i];
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst_enables", i, {mc_re[i], mc_we[i]}, 0);
      check("async_rst_busy", i, {f_busy[i], d_busy[i]}, 0);
      check("async_rst_fields", i, {mc_address[i], mc_writeData[i], mc_SizeLoad[i], mc_MemWrite[i]}, 0);
      check("async_rst_rdata", i, {f_rdata[i], d_rdata[i]}, 0);
    end
    step(); step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++)
      check("no_ack_after_abort", i, (n_fack[i] - snap_f[i]) + (n_dack[i] - snap_d[i]), 0);
    link_fixed = 1'b1; link_val = 8'h5A;
    req_f(8'h77, 3'b011); step(); no_req();
    wait_acks(n_fack[0] + n_dack[0] + 1, n_fack[1] + n_dack[1] + 1);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_rdata", i, f_rdata[i], 8'h5A);
      check("post_rst_acks", i, n_fack[i] - snap_f[i], 1);
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = data port always wins ties.
REQ-002 clk  input  1  single system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 f_start  input  1  fetch-port request strobe (read only), one-cycle pulse.
REQ-005 f_addr / f_size  input  8 / 3  fetch address and SizeLoad code, sampled with f_start.
REQ-006 f_busy / f_ack / f_rdata  output  1 / 1 / 8  pending-or-in-flight flag, one-cycle completion pulse, read data valid with f_ack.
REQ-007 d_start  input  1  data-port request strobe, one-cycle pulse.
REQ-008 d_we / d_addr / d_wdata / d_size / d_memwrite  input  1/8/8/3/2  write select, address, write data, SizeLoad, MemWrite; sampled with d_start.
REQ-009 d_busy / d_ack / d_rdata  output  1 / 1 / 8  same meaning as the fetch outputs; d_rdata holds its last value after a write.
REQ-010 mc_write_enable / mc_read_enable  output  1 / 1  enables to the UART memory link controller.
REQ-011 mc_address / mc_writeData / mc_SizeLoad / mc_MemWrite  output  8/8/3/2  transaction fields to the link controller.
REQ-012 mc_mem_done / mc_readData  input  1 / 8  completion pulse and read data from the link controller.

Function
REQ-013 Per-port holding register captures all request fields when start=1 and busy=0; pending bit set the same edge.
REQ-014 start while busy=1 (including the ack cycle) is ignored; holding register unchanged.
REQ-015 busy = pending OR in-flight OR ack-cycle; busy goes low the cycle after ack.
REQ-016 FSM states IDLE, ISSUE, RESP.
REQ-017 IDLE: if any pending bit set, grant one, copy its holding register into the mc_* output registers, clear its pending bit, go ISSUE next edge.
REQ-018 Arbitration with both pending: FIXED_PRIO=0 grants the port not granted last; FIXED_PRIO=1 grants data.
REQ-019 A start arriving in IDLE is granted no earlier than the following cycle (pending bit must be registered first).
REQ-020 ISSUE: mc_read_enable=1 for fetch or data with d_we=0; mc_write_enable=1 for data with d_we=1; never both; mc_* fields stable throughout.
REQ-021 ISSUE with mc_mem_done=1: capture mc_readData into granted port's rdata (reads only), go RESP.
REQ-022 RESP: both enables 0, granted port's ack=1 for exactly one cycle, update last-grant, go IDLE.
REQ-023 Enables are low in the cycle after mc_mem_done so the link controller returns to its idle state without relaunch.
REQ-024 mc_mem_done outside ISSUE is ignored.
REQ-025 No timeout; ISSUE waits indefinitely for mc_mem_done.
REQ-026 Back-to-back: minimum gap between transactions is two cycles with both enables low (RESP, IDLE).

Reset
REQ-027 On reset: state IDLE, pending bits 0, enables 0, acks 0, busy 0, rdata 0, mc_* fields 0, last-grant = data (fetch wins first tie).
REQ-028 Reset mid-transaction aborts it with no ack; the link controller shares the same reset and aborts too.

Structure
REQ-029 State encodings and the port index constants (PORT_FETCH, PORT_DATA) belong in the shared memory-link package.
REQ-030 One sub-module is natural: mem_req_slot (holding register + pending bit), instantiated once per port.

Verification
REQ-031 Fetch read addr 0x10 size 3'b010, link model returns 0xA5 -> mc_read_enable high until done, f_ack one cycle, f_rdata=0xA5.
REQ-032 Data write addr 0x20 wdata 0x3C memwrite 2'b01 -> mc_write_enable only, fields stable, d_ack one cycle, d_rdata unchanged.
REQ-033 f_start and d_start same cycle, FIXED_PRIO=0 after reset -> fetch first, then data; repeated -> strict alternation.
REQ-034 FIXED_PRIO=1, both ports continuously restarting -> data always wins ties; fetch served only when data not pending.
REQ-035 d_start while d_busy=1 with different addr -> ignored; original transaction completes, only one d_ack.
REQ-036 Reset asserted during ISSUE -> all outputs zero asynchronously, no ack; new f_start after release completes normally.
